bram_matrix_sequencer: RTL and testbench
========================================

BRAM_MATRIX_SEQUENCER -- requirements
Module: bram_matrix_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, element width; SHALL match the local bram data width.
REQ-002 Parameter ADDR_W, default 12, bram address width.
REQ-003 Parameter DIM_W, default 6, width of the row and column counts.
REQ-004 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_op  in  1  0 = LOAD (stream into bram), 1 = STORE (bram out to stream).
REQ-008 cmd_base  in  ADDR_W  address of element (0,0).
REQ-009 cmd_stride  in  ADDR_W  row pitch in elements.
REQ-010 cmd_rows, cmd_cols  in  DIM_W  matrix dimensions.
REQ-011 in_data/in_valid/in_ready  in/in/out  DATA_W/1/1  element input stream for LOAD.
REQ-012 out_data/out_valid/out_ready  out/out/in  DATA_W/1/1  element output stream for STORE.
REQ-013 mem_addr/mem_data/mem_wre  out  ADDR_W/DATA_W/1  drive bram addr/data/wre.
REQ-014 mem_q  in  DATA_W  bram read data, valid one clk after mem_addr is presented.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, LOAD, RD, OUT and FIN.
REQ-018 cmd_ready SHALL equal (state == IDLE); a command SHALL be accepted on cmd_valid && cmd_ready, capturing all cmd_* fields.
REQ-019 Accepted command with rows == 0 or cols == 0 SHALL transition IDLE -> FIN with no memory access and no stream handshake.
REQ-020 Element (r,c) address SHALL be (base + r*stride + c) mod 2^ADDR_W, computed by an accumulated row pointer, with no multiplier.
REQ-021 LOAD: in_ready SHALL be high in LOAD; each in_valid && in_ready SHALL produce, in the next cycle, mem_wre=1 with mem_addr/mem_data set to that element; the traversal order SHALL be row-major.
REQ-022 mem_wre SHALL be 0 in every cycle not following a LOAD handshake.
REQ-023 After the handshake of element (rows-1, cols-1), LOAD SHALL go to FIN.
REQ-024 STORE: RD SHALL present mem_addr for the current element (mem_wre=0) for one cycle, then go to OUT.
REQ-025 On entry to OUT, mem_q SHALL be registered into out_data and out_valid raised; out_data/out_valid SHALL hold stable until out_ready.
REQ-026 On out_valid && out_ready, the FSM SHALL advance to the next element (OUT -> RD), or to FIN after the last element; peak STORE throughput SHALL be one element per 2 cycles.
REQ-027 FIN SHALL assert done for exactly one cycle, then return to IDLE; the next command SHALL be acceptable in the cycle after done.
REQ-028 Column and row counters SHALL wrap c: cols-1 -> 0 with r incremented; address arithmetic SHALL wrap silently at 2^ADDR_W.
REQ-029 in_valid during STORE and out_ready during LOAD SHALL be ignored.

Reset
REQ-030 With rst_n low, the FSM SHALL go to IDLE immediately, mid-operation included; the in-flight command SHALL be dropped and no done SHALL be produced.
REQ-031 Reset values: cmd_ready=1, in_ready=0, out_valid=0, out_data=0, mem_wre=0, mem_addr=0, mem_data=0, busy=0, done=0.

Configuration
REQ-032 Macro TRANSPOSE_EN SHALL control STORE traversal order.
REQ-033 With TRANSPOSE_EN defined, STORE SHALL traverse column-major (outer c, inner r), emitting the transpose.
REQ-034 Without TRANSPOSE_EN, STORE SHALL traverse row-major.
REQ-035 LOAD SHALL be row-major in both builds.

Verification
REQ-036 LOAD with base=0x100, stride=4, rows=2, cols=3, in_data 1..6 -> writes to 0x100,101,102,104,105,106 with data 1..6; done one cycle after the last write.
REQ-037 STORE of the same region, out_ready=1 -> out_data 1,2,3,4,5,6 (row-major) or 1,4,2,5,3,6 (TRANSPOSE_EN); one element every 2 cycles.
REQ-038 STORE with out_ready low for 5 cycles on the 2nd element -> out_data=2 held stable with out_valid=1, no extra mem_addr change, no element lost.
REQ-039 LOAD with base=0xFFE, stride=1, rows=1, cols=4 -> writes to 0xFFE,0xFFF,0x000,0x001.
REQ-040 Command rows=0, cols=5 -> done pulses 2 cycles after acceptance; mem_wre stays 0 and in_ready stays 0.
REQ-041 rst_n low after the 3rd LOAD element -> state IDLE, all outputs at reset values, no done; a fresh command is accepted afterwards.

Source files
------------

// File: rtl/bram_matrix_sequencer_if.sv
// Command, element-stream and bram-port bundle for bram_matrix_sequencer.
// slave is the sequencer side; master is the command/stream/bram side.
interface bram_matrix_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_stride;
    logic [DIM_W-1:0]  cmd_rows;
    logic [DIM_W-1:0]  cmd_cols;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wre;
    logic [DATA_W-1:0] mem_q;

    logic              busy;
    logic              done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_stride, cmd_rows, cmd_cols,
        input  in_data, in_valid, out_ready, mem_q,
        output cmd_ready, in_ready, out_data, out_valid,
        output mem_addr, mem_data, mem_wre, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_stride, cmd_rows, cmd_cols,
        output in_data, in_valid, out_ready, mem_q,
        input  cmd_ready, in_ready, out_data, out_valid,
        input  mem_addr, mem_data, mem_wre, busy, done
    );
endinterface

// File: rtl/bram_matrix_sequencer.sv
// Moves a strided rows x cols matrix between element streams and a bram.
// Define TRANSPOSE_EN to emit STORE results column-major (the transpose).
module bram_matrix_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 6
) (
    input logic clk,
    input logic rst_n,
    bram_matrix_sequencer_if.slave bus
);

`ifdef TRANSPOSE_EN
    localparam bit TRANSPOSE = 1'b1;
`else
    localparam bit TRANSPOSE = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, RD, OUT, FIN} state_t;

    state_t state, state_nxt;

    logic              op_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] row_ptr_q;
    logic [DIM_W-1:0]  rows_q;
    logic [DIM_W-1:0]  cols_q;
    logic [DIM_W-1:0]  r_q;
    logic [DIM_W-1:0]  c_q;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              mem_wre_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              done_q;

    logic              cmd_ready_c;
    logic              in_ready_c;
    logic              busy_c;

    logic              cmd_fire;
    logic              in_fire;
    logic              out_fire;
    logic              cmd_empty;
    logic              last;
    logic              r_wrap;
    logic              c_wrap;
    logic [DIM_W-1:0]  r_nxt;
    logic [DIM_W-1:0]  c_nxt;
    logic [ADDR_W-1:0] row_ptr_nxt;
    logic [ADDR_W-1:0] addr_cur;
    logic [ADDR_W-1:0] addr_nxt;

    assign cmd_fire  = bus.cmd_valid && (state == IDLE);
    assign in_fire   = bus.in_valid && (state == LOAD);
    assign out_fire  = out_valid_q && bus.out_ready && (state == OUT);
    assign cmd_empty = (bus.cmd_rows == '0) || (bus.cmd_cols == '0);
    assign r_wrap    = (r_q == rows_q - DIM_W'(1));
    assign c_wrap    = (c_q == cols_q - DIM_W'(1));
    assign last      = r_wrap && c_wrap;

    // row_ptr_q always holds base + r*stride, so an element address is one add away
    assign addr_cur  = row_ptr_q + ADDR_W'(c_q);
    assign addr_nxt  = row_ptr_nxt + ADDR_W'(c_nxt);

    always_comb begin
        r_nxt       = r_q;
        c_nxt       = c_q;
        row_ptr_nxt = row_ptr_q;
        if (TRANSPOSE && op_q) begin
            if (r_wrap) begin
                r_nxt       = '0;
                c_nxt       = c_q + DIM_W'(1);
                row_ptr_nxt = base_q;
            end else begin
                r_nxt       = r_q + DIM_W'(1);
                row_ptr_nxt = row_ptr_q + stride_q;
            end
        end else begin
            if (c_wrap) begin
                c_nxt       = '0;
                r_nxt       = r_q + DIM_W'(1);
                row_ptr_nxt = row_ptr_q + stride_q;
            end else begin
                c_nxt       = c_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready_c = 1'b0;
        in_ready_c  = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                busy_c      = 1'b0;
                if (cmd_fire) begin
                    state_nxt = cmd_empty ? FIN : (bus.cmd_op ? RD : LOAD);
                end
            end
            LOAD: begin
                in_ready_c = 1'b1;
                if (in_fire && last) state_nxt = FIN;
            end
            RD:   state_nxt = OUT;
            OUT:  if (out_fire) state_nxt = last ? FIN : RD;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 1'b0;
            base_q      <= '0;
            stride_q    <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            r_q         <= '0;
            c_q         <= '0;
            row_ptr_q   <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_wre_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_wre_q <= 1'b0;
            done_q    <= (state == FIN);
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        op_q      <= bus.cmd_op;
                        base_q    <= bus.cmd_base;
                        stride_q  <= bus.cmd_stride;
                        rows_q    <= bus.cmd_rows;
                        cols_q    <= bus.cmd_cols;
                        r_q       <= '0;
                        c_q       <= '0;
                        row_ptr_q <= bus.cmd_base;
                        if (bus.cmd_op && !cmd_empty) mem_addr_q <= bus.cmd_base;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        mem_wre_q  <= 1'b1;
                        mem_addr_q <= addr_cur;
                        mem_data_q <= bus.in_data;
                        r_q        <= r_nxt;
                        c_q        <= c_nxt;
                        row_ptr_q  <= row_ptr_nxt;
                    end
                end
                // mem_addr has been presented for a full cycle, so mem_q is valid here
                RD: begin
                    out_data_q  <= bus.mem_q;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        if (!last) begin
                            r_q        <= r_nxt;
                            c_q        <= c_nxt;
                            row_ptr_q  <= row_ptr_nxt;
                            mem_addr_q <= addr_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_wre   = mem_wre_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bram_matrix_sequencer.sv
// Randomized bench for bram_matrix_sequencer: a bram model plus a reference
// memory image and nested-loop address model predict every write and output.
module tb_bram_matrix_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;

  logic [7:0]  bram    [4096];
  logic [7:0]  ref_mem [4096];

  logic [11:0] wr_a[$];
  logic [7:0]  wr_d[$];
  int          wr_c[$];
  int          done_cycs[$];
  int          inrdy_cnt = 0;

  bram_matrix_sequencer_if #(.DATA_W(8), .ADDR_W(12), .DIM_W(6)) bus ();

  bram_matrix_sequencer #(.DATA_W(8), .ADDR_W(12), .DIM_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_q = bram[bus.mem_addr];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      bram[i]    = 8'($urandom);
      ref_mem[i] = bram[i];
    end
    forever begin
      @(posedge clk);
      if (bus.mem_wre) bram[bus.mem_addr] = bus.mem_data;
    end
  end

  always @(negedge clk) begin
    if (bus.mem_wre) begin
      wr_a.push_back(bus.mem_addr);
      wr_d.push_back(bus.mem_data);
      wr_c.push_back(cyc);
    end
    if (bus.done) done_cycs.push_back(cyc);
    if (bus.in_ready) inrdy_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached after %0d checks, required normal completion", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] elem_addr(input logic [11:0] base, input logic [11:0] stride,
                                            input int r, input int c);
    int a;
    a = (int'(base) + r * int'(stride) + c) % 4096;
    return 12'(a);
  endfunction

  task automatic check_reset_vals(input string p);
    chk({p, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
    chk({p, "_in_ready"},  32'(bus.in_ready),  0);
    chk({p, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({p, "_out_data"},  32'(bus.out_data),  0);
    chk({p, "_mem_wre"},   32'(bus.mem_wre),   0);
    chk({p, "_mem_addr"},  32'(bus.mem_addr),  0);
    chk({p, "_mem_data"},  32'(bus.mem_data),  0);
    chk({p, "_busy"},      32'(bus.busy),      0);
    chk({p, "_done"},      32'(bus.done),      0);
  endtask

  task automatic start_op();
    @(posedge clk);
    #2;
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
    done_cycs.delete();
    inrdy_cnt = 0;
  endtask

  task automatic issue(input logic op, input logic [11:0] base, input logic [11:0] stride,
                       input logic [5:0] rows, input logic [5:0] cols, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_base   = base;
    bus.cmd_stride = stride;
    bus.cmd_rows   = rows;
    bus.cmd_cols   = cols;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    acc = cyc;
    if (!bus.cmd_ready) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 1'($urandom);
    bus.cmd_base   = 12'($urandom);
    bus.cmd_stride = 12'($urandom);
    bus.cmd_rows   = 6'($urandom);
    bus.cmd_cols   = 6'($urandom);
    chk("busy_after_cmd", 32'(bus.busy), 1);
    chk("cmd_ready_when_busy", 32'(bus.cmd_ready), 0);
  endtask

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    while (done_cycs.size() == 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, 32'(done_cycs.size()), 1);
  endtask

  task automatic run_load(input logic [11:0] base, input logic [11:0] stride,
                          input logic [5:0] rows, input logic [5:0] cols, input bit directed);
    logic [7:0] d[$];
    int n, idx, guard, acc, k;
    n = int'(rows) * int'(cols);
    for (int i = 0; i < n; i++) d.push_back(directed ? 8'(i + 1) : 8'($urandom));
    start_op();
    issue(1'b0, base, stride, rows, cols, acc);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      bus.out_ready = 1'($urandom);
      bus.in_valid  = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.in_data   = d[idx];
      if (bus.in_valid && bus.in_ready) idx++;
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (idx < n) chk("load_handshake_timeout", 32'(idx), 32'(n));
    wait_done("load");
    chk("load_write_count", 32'(wr_a.size()), 32'(n));
    k = 0;
    for (int r = 0; r < int'(rows); r++) begin
      for (int c = 0; c < int'(cols); c++) begin
        if (k < wr_a.size()) begin
          chk("load_wr_addr", 32'(wr_a[k]), 32'(elem_addr(base, stride, r, c)));
          chk("load_wr_data", 32'(wr_d[k]), 32'(d[k]));
        end
        ref_mem[elem_addr(base, stride, r, c)] = d[k];
        k++;
      end
    end
    if (done_cycs.size() > 0 && wr_c.size() > 0)
      chk("load_done_latency", 32'(done_cycs[0]), 32'(wr_c[wr_c.size() - 1] + 1));
  endtask

  task automatic run_store(input logic [11:0] base, input logic [11:0] stride,
                           input logic [5:0] rows, input logic [5:0] cols,
                           input int stall_at, input int stall_len, input bit rnd);
    logic [7:0]  exp_d[$];
    logic [7:0]  out_d[$];
    int          out_c[$];
    logic [7:0]  hold_d;
    logic [11:0] hold_a;
    int n, got, guard, acc, stalled;
`ifdef TRANSPOSE_EN
    for (int c = 0; c < int'(cols); c++)
      for (int r = 0; r < int'(rows); r++)
        exp_d.push_back(ref_mem[elem_addr(base, stride, r, c)]);
`else
    for (int r = 0; r < int'(rows); r++)
      for (int c = 0; c < int'(cols); c++)
        exp_d.push_back(ref_mem[elem_addr(base, stride, r, c)]);
`endif
    n = exp_d.size();
    hold_d = '0;
    hold_a = '0;
    start_op();
    issue(1'b1, base, stride, rows, cols, acc);
    got = 0;
    guard = 0;
    stalled = 0;
    while (got < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      bus.in_valid = 1'($urandom);
      bus.in_data  = 8'($urandom);
      if (got == stall_at && stalled > 0 && stalled < stall_len) begin
        chk("stall_out_valid", 32'(bus.out_valid), 1);
        chk("stall_out_data", 32'(bus.out_data), 32'(hold_d));
        chk("stall_mem_addr", 32'(bus.mem_addr), 32'(hold_a));
        bus.out_ready = 1'b0;
        stalled++;
      end else if (got == stall_at && stalled == 0 && stall_len > 0 && bus.out_valid) begin
        hold_d = bus.out_data;
        hold_a = bus.mem_addr;
        bus.out_ready = 1'b0;
        stalled = 1;
      end else begin
        bus.out_ready = rnd ? 1'($urandom) : 1'b1;
        if (bus.out_valid && bus.out_ready) begin
          out_d.push_back(bus.out_data);
          out_c.push_back(cyc);
          got++;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    if (got < n) chk("store_handshake_timeout", 32'(got), 32'(n));
    wait_done("store");
    chk("store_out_count", 32'(out_d.size()), 32'(n));
    for (int k = 0; k < out_d.size() && k < n; k++) chk("store_out_data", 32'(out_d[k]), 32'(exp_d[k]));
    chk("store_no_writes", 32'(wr_a.size()), 0);
    chk("store_in_ready_low", 32'(inrdy_cnt), 0);
    if (!rnd && stall_len == 0)
      for (int k = 1; k < out_c.size(); k++) chk("store_rate", 32'(out_c[k] - out_c[k - 1]), 2);
    if (done_cycs.size() > 0 && out_c.size() > 0)
      chk("store_done_latency", 32'(done_cycs[0]), 32'(out_c[out_c.size() - 1] + 2));
  endtask

  task automatic run_empty(input logic op, input logic [5:0] rows, input logic [5:0] cols);
    int acc;
    start_op();
    issue(op, 12'($urandom), 12'($urandom), rows, cols, acc);
    wait_done("empty");
    if (done_cycs.size() > 0) chk("empty_done_latency", 32'(done_cycs[0]), 32'(acc + 2));
    chk("empty_no_writes", 32'(wr_a.size()), 0);
    chk("empty_in_ready_low", 32'(inrdy_cnt), 0);
  endtask

  task automatic run_reset_midload();
    int acc, idx, guard;
    start_op();
    issue(1'b0, 12'h800, 12'd8, 6'd2, 6'd4, acc);
    idx = 0;
    guard = 0;
    while (idx < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      if (bus.in_valid && bus.in_ready) idx++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_writes_before", 32'(wr_a.size()), 3);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_mid_no_done", 32'(done_cycs.size()), 0);
    chk("rst_mid_no_more_writes", 32'(wr_a.size()), 3);
  endtask

  initial begin
    logic [11:0] b, s;
    logic [5:0]  rr, cc;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 1'b0;
    bus.cmd_base   = '0;
    bus.cmd_stride = '0;
    bus.cmd_rows   = '0;
    bus.cmd_cols   = '0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    #1;
    rst_n = 1'b1;

    run_load(12'h100, 12'd4, 6'd2, 6'd3, 1'b1);
    run_store(12'h100, 12'd4, 6'd2, 6'd3, -1, 0, 1'b0);
    run_store(12'h100, 12'd4, 6'd2, 6'd3, 1, 5, 1'b0);
    run_load(12'hFFE, 12'd1, 6'd1, 6'd4, 1'b1);
    run_store(12'hFFE, 12'd1, 6'd1, 6'd4, -1, 0, 1'b0);
    run_empty(1'b0, 6'd0, 6'd5);
    run_empty(1'b1, 6'd3, 6'd0);

    for (int it = 0; it < 8; it++) begin
      b  = 12'($urandom);
      s  = 12'($urandom_range(0, 12));
      rr = 6'($urandom_range(1, 4));
      cc = 6'($urandom_range(1, 5));
      run_load(b, s, rr, cc, 1'b0);
      run_store(b, s, rr, cc, (it % 3 == 0) ? int'($urandom_range(0, 2)) : -1, 3, 1'b1);
    end

    run_reset_midload();
    run_load(12'h300, 12'd3, 6'd2, 6'd2, 1'b0);
    run_store(12'h300, 12'd3, 6'd2, 6'd2, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
